// File: rtl/signal_generator.sv
// Programmable square-wave source: N clk high, N clk low, continuous or fixed-length burst.
// Period changes are deferred to whole-cycle boundaries, so the output never shows a runt pulse.
module signal_generator #(
  parameter int PERIOD_WIDTH = 16,
  parameter int BURST_WIDTH  = 8,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PERIOD_WIDTH-1:0] half_period,
  input  logic                    period_load,
  input  logic                    enable,
  input  logic [BURST_WIDTH-1:0]  burst_count,
  input  logic                    burst_start,
  output logic                    signal,
  output logic                    busy,
  output logic [COUNT_WIDTH-1:0]  cycle_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_BURST
  } state_t;

  localparam logic [PERIOD_WIDTH-1:0] PERIOD_ONE = PERIOD_WIDTH'(1);
  localparam logic [BURST_WIDTH-1:0]  BURST_ONE  = BURST_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0]  COUNT_ONE  = COUNT_WIDTH'(1);

  state_t                  r_state;
  logic                    r_signal;
  logic [PERIOD_WIDTH-1:0] r_phase;
  logic [PERIOD_WIDTH-1:0] r_active;
  logic [PERIOD_WIDTH-1:0] r_pending;
  logic                    r_pending_valid;
  logic [BURST_WIDTH-1:0]  r_remaining;
  logic [COUNT_WIDTH-1:0]  r_cycles;

  logic                    w_running;
  logic                    w_phase_end;
  logic                    w_boundary;
  logic                    w_apply;
  logic [PERIOD_WIDTH-1:0] w_next_period;
  logic                    w_can_start;

  assign w_running     = (r_state != ST_IDLE);
  assign w_phase_end   = w_running && (r_phase == (r_active - PERIOD_ONE));
  assign w_boundary    = w_phase_end && !r_signal;
  assign w_apply       = r_pending_valid && ((r_state == ST_IDLE) || w_boundary);
  assign w_next_period = r_pending_valid ? r_pending : r_active;
  // A start is refused if the pending value about to land in IDLE would stop the wave anyway.
  assign w_can_start   = (r_active != '0) && (w_next_period != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_signal        <= 1'b0;
      r_phase         <= '0;
      r_active        <= '0;
      r_pending       <= '0;
      r_pending_valid <= 1'b0;
      r_remaining     <= '0;
      r_cycles        <= '0;
    end else begin
      // A fresh load always wins over clearing, so a load on a boundary waits for the next one.
      if (period_load) begin
        r_pending       <= half_period;
        r_pending_valid <= 1'b1;
      end else if (w_apply) begin
        r_pending_valid <= 1'b0;
      end
      if (w_apply) begin
        r_active <= r_pending;
      end

      case (r_state)
        ST_IDLE: begin
          r_signal <= 1'b0;
          r_phase  <= '0;
          if (enable && w_can_start) begin
            r_state  <= ST_RUN;
            r_signal <= 1'b1;
          end else if (burst_start && (burst_count != '0) && w_can_start) begin
            r_state     <= ST_BURST;
            r_signal    <= 1'b1;
            r_remaining <= burst_count;
          end
        end

        ST_RUN, ST_BURST: begin
          if (!w_phase_end) begin
            r_phase <= r_phase + PERIOD_ONE;
          end else begin
            r_phase <= '0;
            if (r_signal) begin
              r_signal <= 1'b0;
            end else begin
              r_cycles <= r_cycles + COUNT_ONE;
              if ((w_next_period == '0) ||
                  ((r_state == ST_RUN) && !enable) ||
                  ((r_state == ST_BURST) && (r_remaining == BURST_ONE))) begin
                r_state     <= ST_IDLE;
                r_signal    <= 1'b0;
                r_remaining <= '0;
              end else begin
                r_signal <= 1'b1;
                if (r_state == ST_BURST) begin
                  r_remaining <= r_remaining - BURST_ONE;
                end
              end
            end
          end
        end

        default: begin
          r_state  <= ST_IDLE;
          r_signal <= 1'b0;
          r_phase  <= '0;
        end
      endcase
    end
  end

  assign signal      = r_signal;
  assign busy        = w_running;
  assign cycle_count = r_cycles;

endmodule

// File: tb/tb_signal_generator.sv
// Directed bench for signal_generator: continuous, burst, period change, stop and async reset.
// Expected values are hand-derived cycle by cycle from the period/boundary rules.
module tb_signal_generator;

  logic        clk;
  logic        reset;
  logic [15:0] half_period;
  logic        period_load;
  logic        enable;
  logic [7:0]  burst_count;
  logic        burst_start;
  logic        signal;
  logic        busy;
  logic [15:0] cycle_count;

  int vectorCount = 0;
  int missCount   = 0;

  signal_generator #(
    .PERIOD_WIDTH(16),
    .BURST_WIDTH (8),
    .COUNT_WIDTH (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .half_period(half_period),
    .period_load(period_load),
    .enable     (enable),
    .burst_count(burst_count),
    .burst_start(burst_start),
    .signal     (signal),
    .busy       (busy),
    .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n clocks and land 1 time unit past the edge, where outputs are stable.
  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic loadPeriod(input logic [15:0] n);
    half_period = n;
    period_load = 1'b1;
    applyStimulus(1);
    period_load = 1'b0;
    applyStimulus(1);
  endtask

  task automatic checkOutput(input string tag, input logic expSig, input logic expBusy,
                             input logic [15:0] expCycles);
    vectorCount++;
    assert (signal === expSig) else begin
      missCount++;
      $error("[TB] FAIL %s signal observed=%0b expected=%0b", tag, signal, expSig);
    end
    vectorCount++;
    assert (busy === expBusy) else begin
      missCount++;
      $error("[TB] FAIL %s busy observed=%0b expected=%0b", tag, busy, expBusy);
    end
    vectorCount++;
    assert (cycle_count === expCycles) else begin
      missCount++;
      $error("[TB] FAIL %s cycle_count observed=%0d expected=%0d", tag, cycle_count, expCycles);
    end
  endtask

  // Guards against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset       = 1'b1;
    half_period = '0;
    period_load = 1'b0;
    enable      = 1'b0;
    burst_count = '0;
    burst_start = 1'b0;
    #12;
    checkOutput("reset", 1'b0, 1'b0, 16'd0);
    reset = 1'b0;
    applyStimulus(1);

    // Continuous N=3: 3 high, 3 low, one count per 6 clocks, stop at the boundary.
    loadPeriod(16'd3);
    checkOutput("s1_idle", 1'b0, 1'b0, 16'd0);
    enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1);
      checkOutput($sformatf("s1_%0d", i), ((i % 6) < 3), 1'b1, 16'(i / 6));
    end
    enable = 1'b0;
    applyStimulus(1);
    checkOutput("s1_stop", 1'b0, 1'b0, 16'd2);

    // N=1 toggles each clock; enable dropped during a high phase completes that cycle.
    loadPeriod(16'd1);
    enable = 1'b1;
    for (int k = 0; k < 9; k++) begin
      applyStimulus(1);
      checkOutput($sformatf("s2_%0d", k), ((k % 2) == 0), 1'b1, 16'(2 + k / 2));
    end
    enable = 1'b0;
    applyStimulus(1);
    checkOutput("s2_tail", 1'b0, 1'b1, 16'd6);
    applyStimulus(1);
    checkOutput("s2_stop", 1'b0, 1'b0, 16'd7);

    // Burst of 4 at N=2, with a stray burst_start mid-burst; then burst_count=0.
    loadPeriod(16'd2);
    burst_count = 8'd4;
    burst_start = 1'b1;
    for (int j = 0; j < 16; j++) begin
      applyStimulus(1);
      if (j == 0) burst_start = 1'b0;
      checkOutput($sformatf("s3_%0d", j), ((j % 4) < 2), 1'b1, 16'(7 + j / 4));
      if (j == 5) begin
        burst_start = 1'b1;
        burst_count = 8'd8;
      end
      if (j == 6) burst_start = 1'b0;
    end
    applyStimulus(1);
    checkOutput("s3_end", 1'b0, 1'b0, 16'd11);
    burst_count = 8'd0;
    burst_start = 1'b1;
    applyStimulus(1);
    checkOutput("s3_zero", 1'b0, 1'b0, 16'd11);
    burst_start = 1'b0;
    applyStimulus(1);
    checkOutput("s3_zero_hold", 1'b0, 1'b0, 16'd11);

    // N=5 -> 2 loaded mid high phase; later N=0 loaded on a boundary cycle.
    loadPeriod(16'd5);
    enable = 1'b1;
    for (int m = 0; m < 22; m++) begin
      logic        expSig;
      logic [15:0] expCyc;
      applyStimulus(1);
      if (m < 5)       expSig = 1'b1;
      else if (m < 10) expSig = 1'b0;
      else             expSig = (((m - 10) % 4) < 2);
      expCyc = (m < 10) ? 16'd11 : 16'(12 + (m - 10) / 4);
      checkOutput($sformatf("s4_%0d", m), expSig, 1'b1, expCyc);
      if (m == 2) begin
        half_period = 16'd2;
        period_load = 1'b1;
      end
      if (m == 3) begin
        period_load = 1'b0;
        half_period = 16'd7;
      end
      if (m == 17) begin
        half_period = 16'd0;
        period_load = 1'b1;
      end
      if (m == 18) period_load = 1'b0;
    end
    applyStimulus(1);
    checkOutput("s4_zero_stop", 1'b0, 1'b0, 16'd15);
    applyStimulus(1);
    checkOutput("s4_zero_idle", 1'b0, 1'b0, 16'd15);
    enable = 1'b0;

    // enable and burst_start together: continuous run outlasts the 2-cycle burst.
    loadPeriod(16'd1);
    enable      = 1'b1;
    burst_start = 1'b1;
    burst_count = 8'd2;
    for (int p = 0; p < 6; p++) begin
      applyStimulus(1);
      if (p == 0) burst_start = 1'b0;
      checkOutput($sformatf("s5_%0d", p), ((p % 2) == 0), 1'b1, 16'(15 + p / 2));
    end
    enable = 1'b0;
    applyStimulus(1);
    checkOutput("s5_stop", 1'b0, 1'b0, 16'd18);

    // enable raised during a burst: RUN begins one clock after the burst ends.
    burst_count = 8'd2;
    burst_start = 1'b1;
    applyStimulus(1);
    burst_start = 1'b0;
    enable      = 1'b1;
    checkOutput("s6_0", 1'b1, 1'b1, 16'd18);
    applyStimulus(1);
    checkOutput("s6_1", 1'b0, 1'b1, 16'd18);
    applyStimulus(1);
    checkOutput("s6_2", 1'b1, 1'b1, 16'd19);
    applyStimulus(1);
    checkOutput("s6_3", 1'b0, 1'b1, 16'd19);
    applyStimulus(1);
    checkOutput("s6_burst_end", 1'b0, 1'b0, 16'd20);
    applyStimulus(1);
    checkOutput("s6_run_start", 1'b1, 1'b1, 16'd20);
    applyStimulus(1);
    checkOutput("s6_run_low", 1'b0, 1'b1, 16'd20);
    enable = 1'b0;
    applyStimulus(1);
    checkOutput("s6_stop", 1'b0, 1'b0, 16'd21);

    // Asynchronous reset in a high phase, then enable ignored until a new load.
    loadPeriod(16'd4);
    enable = 1'b1;
    applyStimulus(1);
    checkOutput("s7_high0", 1'b1, 1'b1, 16'd21);
    applyStimulus(1);
    checkOutput("s7_high1", 1'b1, 1'b1, 16'd21);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("s7_async", 1'b0, 1'b0, 16'd0);
    reset = 1'b0;
    applyStimulus(1);
    checkOutput("s7_noperiod0", 1'b0, 1'b0, 16'd0);
    applyStimulus(1);
    checkOutput("s7_noperiod1", 1'b0, 1'b0, 16'd0);
    loadPeriod(16'd2);
    checkOutput("s7_applied", 1'b0, 1'b0, 16'd0);
    applyStimulus(1);
    checkOutput("s7_restart", 1'b1, 1'b1, 16'd0);
    enable = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/signal_generator.md
Name: signal_generator

Overview:
- Programmable square-wave source; the transmit-side counterpart to the frequency_counter measurement block.
- Drives an io pad so the counter, or external equipment, can be checked against a known frequency.
- Configured from logic-analyser bits.
- Supports continuous and fixed-length burst output with glitch-free period changes.

Parameters:
PERIOD_WIDTH, 16, width of half-period value, in clk cycles
BURST_WIDTH, 8, width of burst cycle count
COUNT_WIDTH, 16, width of completed-cycle counter

Ports:
clk  input  1  system clock (wb_clk_i at wrapper level)
reset  input  1  asynchronous, active-high reset
half_period  input  PERIOD_WIDTH  requested half-period N, in clk cycles
period_load  input  1  single-cycle strobe; captures half_period into pending register
enable  input  1  level; high requests continuous output
burst_count  input  BURST_WIDTH  number of full cycles to emit in burst mode
burst_start  input  1  single-cycle strobe; starts a burst
signal  output  1  generated square wave
busy  output  1  high whenever state != IDLE
cycle_count  output  COUNT_WIDTH  full cycles completed since reset; wraps

Behaviour:
- Reset (async, active-high):
  - state=IDLE; signal=0; busy=0; cycle_count=0.
  - active_period=0; pending_period=0; pending_valid=0; phase counter=0; burst remaining=0.
- Output frequency = clk / (2*N).
  - High phase is N cycles, then low phase is N cycles.
  - N=0 means stopped.
  - N=1 toggles signal on every clk cycle.
- Phase counter runs 0..N-1. At N-1 it clears and signal toggles.
- Boundary: the cycle where the counter is at N-1 and signal=0, i.e. the end of a full cycle. At each boundary:
  - cycle_count increments, wrapping at 2^COUNT_WIDTH.
  - A pending period is applied.
- States are IDLE, RUN and BURST. busy=1 in RUN and BURST.
- IDLE:
  - signal held 0; counter held 0.
  - If enable=1 and active_period!=0: go to RUN next cycle with signal=1 and counter=0. The first rising edge is 1 cycle after enable is sampled.
  - Otherwise, if burst_start=1 and burst_count!=0 and active_period!=0: go to BURST with remaining=burst_count and signal=1.
  - If enable and burst_start are high in the same cycle, enable wins and the burst is dropped.
  - burst_count=0 or active_period=0: the request is ignored and the block stays IDLE.
- RUN:
  - Toggles continuously.
  - If enable=0 at a boundary: go to IDLE with signal=0. Output always stops after whole cycles, never a truncated high phase.
  - Deasserting enable mid-cycle does not abort; the current cycle completes.
- BURST:
  - remaining decrements at each boundary.
  - At a boundary with remaining==1: go to IDLE. Exactly burst_count full cycles are emitted.
  - enable and burst_start are ignored in BURST.
  - If enable is still high when the burst ends, RUN starts via the IDLE rule on the following cycle.
- period_load:
  - Captures half_period into pending_period and sets pending_valid.
  - In IDLE it is applied on the next cycle: active_period updated, pending_valid cleared.
  - In RUN/BURST it is applied only at the next boundary. The new period takes effect from the next high phase, so there is no runt pulse.
  - A load in the same cycle as a boundary is applied at the following boundary.
  - Back-to-back loads: the last value wins.
  - If the applied value is 0 at a boundary: go to IDLE with signal=0.
- Changing half_period without period_load has no effect.

Test Plan:
- Reset; load N=3; enable=1 -> signal high 3 cycles and low 3 cycles, period 6; busy=1; cycle_count increments every 6 cycles.
- N=1, enable=1 for 10 cycles, then 0 -> signal toggles every cycle; stops low only after a full cycle; busy falls at that boundary.
- N=2, burst_count=4, burst_start pulse -> exactly 4 cycles (16 clk); cycle_count +4; busy=0 afterwards. Repeat with burst_count=0 -> no output, busy stays 0.
- Running N=5; load N=2 midway through a high phase -> current cycle completes at 5/5, then 2/2 cycles; no phase shorter than 2. Load N=0 while running -> stops low at the next boundary.
- enable and burst_start both high in IDLE -> continuous RUN; burst_start during a burst is ignored; enable held through a burst -> RUN starts 1 cycle after the burst ends.
- Assert reset mid-high-phase -> signal, busy and cycle_count read 0 immediately (asynchronously, not waiting for a clk edge); active_period=0, so enable is ignored until a new load.
